mips_cpu_loadstore_unit: RTL and testbench

Load/store unit between the MIPS CPU execute stage and the data port of the Harvard memory. Converts byte, halfword and word load/store requests into word-aligned memory accesses. Extracts and sign/zero-extends load results. Implements sub-word stores as read-modify-write, because the memory data port has no byte enables.

---
 rtl/mips_cpu_loadstore_unit_if.sv | 44 ++++
 rtl/mips_cpu_loadstore_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mips_cpu_loadstore_unit.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_loadstore_unit_if.sv
// mips_cpu_loadstore_unit_if
// Bundles the CPU request/response handshake and the memory data port of the
// load/store unit.
//   req_*   : CPU request (valid/ready, write, size, signed, address, data)
//   resp_*  : response to CPU (valid/ready, readdata, error)
//   data_*  : word-aligned memory data port (address, read, write,
//             writedata, readdata)
// Modports:
//   slave  : the load/store unit
//   master : its environment (CPU execute stage plus the data memory)
interface mips_cpu_loadstore_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_writedata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_readdata;
    logic        resp_error;

    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_address, req_writedata,
        input  resp_ready, data_readdata,
        output req_ready, resp_valid, resp_readdata, resp_error,
        output data_address, data_read, data_write, data_writedata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_address, req_writedata,
        output resp_ready, data_readdata,
        input  req_ready, resp_valid, resp_readdata, resp_error,
        input  data_address, data_read, data_write, data_writedata
    );
endinterface

// File: rtl/mips_cpu_loadstore_unit.sv
// mips_cpu_loadstore_unit
// Converts byte/halfword/word load and store requests from the execute stage
// into word-aligned accesses on a memory data port without byte enables.
// Loads are lane-extracted and sign/zero-extended; sub-word stores are done
// as read-modify-write. Byte order is big-endian.
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mips_cpu_loadstore_unit_if.slave (request, response, data port)
// Parameter:
//   CHECK_ALIGN : 1 = misaligned half/word requests return an error without
//                 touching memory; 0 = offending low address bits are ignored
//
// state | meaning
// IDLE  | ready for a request; request fields captured on accept
// READ  | memory read strobe; word captured (load result or RMW source)
// WRITE | memory write strobe; full word or merged sub-word lane
// RESP  | response held until resp_ready
module mips_cpu_loadstore_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    mips_cpu_loadstore_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_address;
    logic [31:0] r_writedata;
    logic [31:0] r_word;
    logic [31:0] r_readdata;
    logic        r_error;

    logic        req_error;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic [31:0] merged_word;
    logic [31:0] aligned_address;

    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_readdata;
    logic        resp_error;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;

    assign aligned_address = {r_address[31:2], 2'b00};

    always_comb begin
        req_error = (bus.req_size == 2'b11);
        if (CHECK_ALIGN) begin
            if (bus.req_size == 2'b01 && bus.req_address[0])
                req_error = 1'b1;
            if (bus.req_size == 2'b10 && bus.req_address[1:0] != 2'b00)
                req_error = 1'b1;
        end
    end

    // Lane extraction from the live memory word during READ.
    always_comb begin
        load_byte = 8'h00;
        case (r_address[1:0])
            2'd0:    load_byte = bus.data_readdata[31:24];
            2'd1:    load_byte = bus.data_readdata[23:16];
            2'd2:    load_byte = bus.data_readdata[15:8];
            default: load_byte = bus.data_readdata[7:0];
        endcase
        load_half = r_address[1] ? bus.data_readdata[15:0] : bus.data_readdata[31:16];
        case (r_size)
            2'b00:   load_value = {{24{r_signed & load_byte[7]}}, load_byte};
            2'b01:   load_value = {{16{r_signed & load_half[15]}}, load_half};
            default: load_value = bus.data_readdata;
        endcase
    end

    // Store word: full word for SW, otherwise the captured word with one lane replaced.
    always_comb begin
        merged_word = r_word;
        case (r_size)
            2'b00: begin
                case (r_address[1:0])
                    2'd0:    merged_word[31:24] = r_writedata[7:0];
                    2'd1:    merged_word[23:16] = r_writedata[7:0];
                    2'd2:    merged_word[15:8]  = r_writedata[7:0];
                    default: merged_word[7:0]   = r_writedata[7:0];
                endcase
            end
            2'b01: begin
                if (r_address[1])
                    merged_word[15:0] = r_writedata[15:0];
                else
                    merged_word[31:16] = r_writedata[15:0];
            end
            default: merged_word = r_writedata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_readdata  = 32'h0;
        resp_error     = 1'b0;
        data_address   = 32'h0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_writedata = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_error)
                        state_next = RESP;
                    else if (bus.req_write && bus.req_size == 2'b10)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                data_read    = 1'b1;
                data_address = aligned_address;
                state_next   = r_write ? WRITE : RESP;
            end
            WRITE: begin
                data_write     = 1'b1;
                data_address   = aligned_address;
                data_writedata = merged_word;
                state_next     = RESP;
            end
            RESP: begin
                resp_valid    = 1'b1;
                resp_readdata = r_readdata;
                resp_error    = r_error;
                if (bus.resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_address   <= 32'h0;
            r_writedata <= 32'h0;
            r_word      <= 32'h0;
            r_readdata  <= 32'h0;
            r_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write     <= bus.req_write;
                        r_size      <= bus.req_size;
                        r_signed    <= bus.req_signed;
                        r_address   <= bus.req_address;
                        r_writedata <= bus.req_writedata;
                        r_word      <= 32'h0;
                        r_readdata  <= 32'h0;
                        r_error     <= req_error;
                    end
                end
                READ: begin
                    r_word <= bus.data_readdata;
                    if (!r_write)
                        r_readdata <= load_value;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.resp_valid     = resp_valid;
    assign bus.resp_readdata  = resp_readdata;
    assign bus.resp_error     = resp_error;
    assign bus.data_address   = data_address;
    assign bus.data_read      = data_read;
    assign bus.data_write     = data_write;
    assign bus.data_writedata = data_writedata;

endmodule

// File: tb/tb_mips_cpu_loadstore_unit.sv
// tb_mips_cpu_loadstore_unit
// Self-checking bench: a 16-word memory model sits on the data port, expected
// responses are pushed to a scoreboard queue as each request is driven and
// popped when the unit responds.
module tb_mips_cpu_loadstore_unit;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mips_cpu_loadstore_unit_if bus();

    mips_cpu_loadstore_unit #(.CHECK_ALIGN(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (bus.data_write)
            mem[bus.data_address[5:2]] <= bus.data_writedata;
        else if (pre_en)
            mem[pre_idx] <= pre_val;
    end
    assign bus.data_readdata = mem[bus.data_address[5:2]];

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] obs_rd, obs_rdaddr, obs_wraddr, obs_wrdata;
    logic        obs_err, obs_bad, obs_tmo;
    int          obs_lat, obs_nrd, obs_nwr, obs_wait;

    localparam logic [31:0] LD_ADDR [10] = '{32'h3, 32'h6, 32'h6, 32'h4, 32'h4, 32'h4, 32'h4, 32'h2, 32'h1, 32'h2};
    localparam logic [1:0]  LD_SIZE [10] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
    localparam logic        LD_SGN  [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [31:0] LD_EXP  [10] = '{32'hFFFFFFF0, 32'h0000ABCD, 32'hFFFFABCD, 32'h00000080, 32'hFFFFFF80,
                                             32'h8000ABCD, 32'hFFFF8000, 32'h000056F0, 32'h00000034, 32'h00000056};

    localparam logic [1:0]  ST_SIZE [6] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
    localparam logic [31:0] ST_ADDR [6] = '{32'h9, 32'hA, 32'h8, 32'hB, 32'h8, 32'h8};
    localparam logic [31:0] ST_DATA [6] = '{32'h000000AA, 32'hFFFF5566, 32'h12345677, 32'hABCDEFEE, 32'h00009988, 32'hCAFEF00D};
    localparam logic [31:0] ST_EXP  [6] = '{32'h11AA3344, 32'h11AA5566, 32'h77AA5566, 32'h77AA55EE, 32'h998855EE, 32'hCAFEF00D};

    localparam logic        ER_WR   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [1:0]  ER_SIZE [5] = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd1};
    localparam logic [31:0] ER_ADDR [5] = '{32'h6, 32'h0, 32'h9, 32'hD, 32'h3};

    function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] word, output logic [31:0] rd,
                                  output logic err, output int lat, output logic [31:0] nword);
        int          sh;
        logic [31:0] mask, v;
        err   = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
        rd    = 32'h0;
        nword = word;
        lat   = 1;
        sh    = (sz == 2'b00) ? (3 - int'(addr[1:0])) * 8 : (addr[1] ? 0 : 16);
        mask  = (sz == 2'b00) ? (32'hFF << sh) : (32'hFFFF << sh);
        if (!err && wr) begin
            if (sz == 2'b10) begin
                nword = wdata;
                lat   = 2;
            end else begin
                nword = (word & ~mask) | ((wdata << sh) & mask);
                lat   = 3;
            end
        end else if (!err) begin
            lat = 2;
            if (sz == 2'b10) begin
                rd = word;
            end else begin
                v = (word & mask) >> sh;
                if (sg && v[(sz == 2'b00) ? 7 : 15])
                    rd = v | ~(mask >> sh);
                else
                    rd = v;
            end
        end
    endfunction

    task automatic mem_load(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx[3:0];
        pre_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Drives one request with resp_ready high and records what the unit did.
    task automatic do_request(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wdata);
        obs_tmo = 1'b0; obs_bad = 1'b0; obs_nrd = 0; obs_nwr = 0; obs_wait = 0;
        obs_rdaddr = 32'h0; obs_wraddr = 32'h0; obs_wrdata = 32'h0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && obs_wait < 20) begin
            @(negedge clk);
            obs_wait++;
        end
        if (bus.req_ready !== 1'b1) obs_tmo = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz; bus.req_signed = sg;
        bus.req_address = addr; bus.req_writedata = wdata; bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_write = ~wr; bus.req_size = ~sz; bus.req_signed = ~sg;
        bus.req_address = ~addr; bus.req_writedata = ~wdata;
        obs_lat = 1;
        @(negedge clk);
        while (bus.resp_valid !== 1'b1 && obs_lat < 20) begin
            if (bus.data_read === 1'b1) begin obs_nrd++; obs_rdaddr = bus.data_address; end
            if (bus.data_write === 1'b1) begin
                obs_nwr++; obs_wraddr = bus.data_address; obs_wrdata = bus.data_writedata;
            end
            if (bus.data_read === 1'b1 && bus.data_write === 1'b1) obs_bad = 1'b1;
            @(negedge clk);
            obs_lat++;
        end
        if (bus.resp_valid !== 1'b1) obs_tmo = 1'b1;
        if ({bus.req_ready, bus.data_read, bus.data_write} !== 3'b000 ||
            bus.data_address !== 32'h0 || bus.data_writedata !== 32'h0) obs_bad = 1'b1;
        obs_rd  = bus.resp_readdata;
        obs_err = bus.resp_error;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.data_read, bus.data_write} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 10000", {bus.req_ready, bus.resp_valid, bus.resp_error, bus.data_read, bus.data_write});
        end
        n_checks++;
        if ({bus.resp_readdata, bus.data_address, bus.data_writedata} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {bus.resp_readdata, bus.data_address, bus.data_writedata});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.data_read, bus.data_write} !== 4'b1000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 1000", {bus.req_ready, bus.resp_valid, bus.data_read, bus.data_write});
        end
    endtask

    task automatic test_loads();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            e.rd = LD_EXP[i]; e.err = 1'b0; e.lat = 2;
            sb.push_back(e);
            do_request(1'b0, LD_SIZE[i], LD_SGN[i], LD_ADDR[i], 32'h0);
            e = sb.pop_front();
            n_checks++;
            if (obs_tmo !== 1'b0) begin n_fail++; $display("FAIL load%0d_timeout: got %b expected 0", i, obs_tmo); end
            n_checks++;
            if (obs_rd !== e.rd || obs_err !== e.err) begin
                n_fail++; $display("FAIL load%0d_data: got %h/%b expected %h/%b", i, obs_rd, obs_err, e.rd, e.err);
            end
            n_checks++;
            if (obs_lat !== e.lat) begin n_fail++; $display("FAIL load%0d_latency: got %0d expected %0d", i, obs_lat, e.lat); end
            n_checks++;
            if (obs_nrd !== 1 || obs_nwr !== 0 || obs_rdaddr !== {LD_ADDR[i][31:2], 2'b00} || obs_bad !== 1'b0) begin
                n_fail++;
                $display("FAIL load%0d_strobes: got rd=%0d wr=%0d addr=%h bad=%b expected rd=1 wr=0 addr=%h bad=0",
                         i, obs_nrd, obs_nwr, obs_rdaddr, obs_bad, {LD_ADDR[i][31:2], 2'b00});
            end
        end
    endtask

    task automatic test_stores();
        exp_t e;
        int   exp_nrd;
        for (int i = 0; i < 6; i++) begin
            exp_nrd = (ST_SIZE[i] == 2'd2) ? 0 : 1;
            e.rd = 32'h0; e.err = 1'b0; e.lat = (ST_SIZE[i] == 2'd2) ? 2 : 3;
            sb.push_back(e);
            do_request(1'b1, ST_SIZE[i], 1'b0, ST_ADDR[i], ST_DATA[i]);
            e = sb.pop_front();
            ref_mem[2] = ST_EXP[i];
            n_checks++;
            if (obs_tmo !== 1'b0 || obs_rd !== e.rd || obs_err !== e.err) begin
                n_fail++; $display("FAIL store%0d_resp: got tmo=%b %h/%b expected tmo=0 %h/%b", i, obs_tmo, obs_rd, obs_err, e.rd, e.err);
            end
            n_checks++;
            if (obs_lat !== e.lat) begin n_fail++; $display("FAIL store%0d_latency: got %0d expected %0d", i, obs_lat, e.lat); end
            n_checks++;
            if (obs_nrd !== exp_nrd || obs_nwr !== 1 || obs_wraddr !== 32'h8 || obs_wrdata !== ST_EXP[i] ||
                (exp_nrd == 1 && obs_rdaddr !== 32'h8) || obs_bad !== 1'b0) begin
                n_fail++;
                $display("FAIL store%0d_strobes: got rd=%0d wr=%0d waddr=%h wdata=%h bad=%b expected rd=%0d wr=1 waddr=00000008 wdata=%h bad=0",
                         i, obs_nrd, obs_nwr, obs_wraddr, obs_wrdata, obs_bad, exp_nrd, ST_EXP[i]);
            end
            n_checks++;
            if (mem[2] !== ref_mem[2]) begin n_fail++; $display("FAIL store%0d_mem: got %h expected %h", i, mem[2], ref_mem[2]); end
        end
        e.rd = 32'hCAFEF00D; e.err = 1'b0; e.lat = 2;
        sb.push_back(e);
        do_request(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (obs_rd !== e.rd || obs_lat !== e.lat) begin
            n_fail++; $display("FAIL store_readback: got %h lat %0d expected %h lat %0d", obs_rd, obs_lat, e.rd, e.lat);
        end
    endtask

    task automatic test_errors();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            e.rd = 32'h0; e.err = 1'b1; e.lat = 1;
            sb.push_back(e);
            do_request(ER_WR[i], ER_SIZE[i], 1'b1, ER_ADDR[i], 32'hFFFFFFFF);
            e = sb.pop_front();
            n_checks++;
            if (obs_tmo !== 1'b0 || obs_rd !== e.rd || obs_err !== e.err || obs_lat !== e.lat) begin
                n_fail++;
                $display("FAIL err%0d_resp: got tmo=%b rd=%h err=%b lat=%0d expected tmo=0 rd=%h err=%b lat=%0d",
                         i, obs_tmo, obs_rd, obs_err, obs_lat, e.rd, e.err, e.lat);
            end
            n_checks++;
            if (obs_nrd !== 0 || obs_nwr !== 0 || obs_bad !== 1'b0 || mem[ER_ADDR[i][5:2]] !== ref_mem[ER_ADDR[i][5:2]]) begin
                n_fail++;
                $display("FAIL err%0d_no_access: got rd=%0d wr=%0d bad=%b mem=%h expected rd=0 wr=0 bad=0 mem=%h",
                         i, obs_nrd, obs_nwr, obs_bad, mem[ER_ADDR[i][5:2]], ref_mem[ER_ADDR[i][5:2]]);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic held_ok;
        int   lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2; bus.req_signed = 1'b0;
        bus.req_address = 32'hC; bus.req_writedata = 32'hDEADBEEF; bus.resp_ready = 1'b0;
        e.rd = 32'h0; e.err = 1'b0; e.lat = 2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_write = 1'b0; bus.req_address = 32'hC; bus.req_writedata = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({bus.data_write, bus.data_read, bus.req_ready} !== 3'b100 || bus.data_address !== 32'hC ||
            bus.data_writedata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bp_write: got wr/rd/rdy=%b addr=%h data=%h expected 100 0000000c deadbeef",
                     {bus.data_write, bus.data_read, bus.req_ready}, bus.data_address, bus.data_writedata);
        end
        held_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_error !== 1'b0 ||
                bus.resp_readdata !== 32'h0 || bus.data_read !== 1'b0 || bus.data_write !== 1'b0) held_ok = 1'b0;
        end
        e = sb.pop_front();
        n_checks++;
        if (held_ok !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %b expected 1", held_ok); end
        n_checks++;
        if (bus.resp_readdata !== e.rd || bus.resp_error !== e.err) begin
            n_fail++; $display("FAIL bp_resp: got %h/%b expected %h/%b", bus.resp_readdata, bus.resp_error, e.rd, e.err);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.data_read} !== 3'b100) begin
            n_fail++; $display("FAIL bp_after_handshake: got %b expected 100", {bus.req_ready, bus.resp_valid, bus.data_read});
        end
        e.rd = 32'hDEADBEEF; e.err = 1'b0; e.lat = 2;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_readdata !== e.rd || lat !== e.lat) begin
            n_fail++; $display("FAIL bp_second: got v=%b %h lat %0d expected v=1 %h lat %0d", bus.resp_valid, bus.resp_readdata, lat, e.rd, e.lat);
        end
        @(posedge clk);
        #1;
        ref_mem[3] = 32'hDEADBEEF;
        n_checks++;
        if (mem[3] !== ref_mem[3]) begin n_fail++; $display("FAIL bp_mem: got %h expected %h", mem[3], ref_mem[3]); end
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd1; bus.req_signed = 1'b0;
        bus.req_address = 32'h12; bus.req_writedata = 32'h0000BEEF; bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.data_write !== 1'b1 || bus.data_writedata !== 32'h0102BEEF || bus.data_address !== 32'h10) begin
            n_fail++;
            $display("FAIL rst_pre_write: got wr=%b data=%h addr=%h expected 1 0102beef 00000010", bus.data_write, bus.data_writedata, bus.data_address);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.data_read, bus.data_write} !== 5'b10000 ||
            {bus.resp_readdata, bus.data_address, bus.data_writedata} !== 96'h0) begin
            n_fail++;
            $display("FAIL rst_async: got ctrl=%b data=%h expected 10000 0", {bus.req_ready, bus.resp_valid, bus.resp_error,
                     bus.data_read, bus.data_write}, {bus.resp_readdata, bus.data_address, bus.data_writedata});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_no_resp: got v=%b rdy=%b expected 0 1", bus.resp_valid, bus.req_ready);
        end
        e.rd = 32'h0; e.err = 1'b0; e.lat = 3;
        sb.push_back(e);
        do_request(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF);
        e = sb.pop_front();
        ref_mem[4] = 32'h0102BEEF;
        n_checks++;
        if (obs_tmo !== 1'b0 || obs_lat !== e.lat || obs_rd !== e.rd || mem[4] !== ref_mem[4]) begin
            n_fail++;
            $display("FAIL rst_recover: got tmo=%b lat=%0d rd=%h mem=%h expected 0 %0d %h %h", obs_tmo, obs_lat, obs_rd, mem[4], e.lat, e.rd, ref_mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic        wr, sg, err;
        logic [1:0]  sz;
        logic [3:0]  idx;
        logic [1:0]  lo;
        logic [31:0] addr, wdata, rd, nword;
        int          lat, exp_nrd, exp_nwr;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); idx = 4'($urandom_range(8, 15)); lo = 2'($urandom_range(0, 3));
            addr = {26'h0, idx, lo}; wdata = $urandom;
            model(wr, sz, sg, addr, wdata, ref_mem[idx], rd, err, lat, nword);
            exp_nrd = (!err && !(wr && sz == 2'b10)) ? 1 : 0;
            exp_nwr = (!err && wr) ? 1 : 0;
            e.rd = rd; e.err = err; e.lat = lat;
            sb.push_back(e);
            ref_mem[idx] = nword;
            do_request(wr, sz, sg, addr, wdata);
            e = sb.pop_front();
            n_checks++;
            if (obs_tmo !== 1'b0 || obs_wait !== 0 || obs_rd !== e.rd || obs_err !== e.err || obs_lat !== e.lat) begin
                n_fail++;
                $display("FAIL b2b%0d_resp: got tmo=%b wait=%0d rd=%h err=%b lat=%0d expected 0 0 %h %b %0d (wr=%b sz=%0d sg=%b a=%h)",
                         i, obs_tmo, obs_wait, obs_rd, obs_err, obs_lat, e.rd, e.err, e.lat, wr, sz, sg, addr);
            end
            n_checks++;
            if (obs_nrd !== exp_nrd || obs_nwr !== exp_nwr || obs_bad !== 1'b0 || mem[idx] !== ref_mem[idx]) begin
                n_fail++;
                $display("FAIL b2b%0d_mem: got rd=%0d wr=%0d bad=%b mem=%h expected %0d %0d 0 %h", i, obs_nrd, obs_nwr,
                         obs_bad, mem[idx], exp_nrd, exp_nwr, ref_mem[idx]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        pre_en = 1'b0; pre_idx = 4'h0; pre_val = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_address = 32'h0; bus.req_writedata = 32'h0; bus.resp_ready = 1'b0;
        mem_load(0, 32'h123456F0);
        mem_load(1, 32'h8000ABCD);
        mem_load(2, 32'h11223344);
        mem_load(3, 32'h00000000);
        mem_load(4, 32'h01020304);
        for (int i = 5; i < 16; i++) mem_load(i, $urandom);
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
